// File: rtl/store_merge_unit.sv
// Store merge unit: commits byte/halfword/word stores to a word-wide memory,
// doing a read-modify-write for sub-word stores and aborting on ack timeout.
module store_merge_unit #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [1:0]     off_q, off_d;
    logic [15:0]    data_q, data_d;
    logic           is_byte_q, is_byte_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic           err_flag_q, err_flag_d;

    logic           req_is_byte;
    logic           req_is_half;
    logic           req_misaligned;
    logic [31:0]    merged;
    logic [4:0]     byte_lsb;
    logic [4:0]     half_lsb;

    always_comb begin
        req_is_byte    = (req_size == 2'b01);
        req_is_half    = (req_size == 2'b10);
        req_misaligned = (req_is_half && req_addr[0])
                      || (!req_is_byte && !req_is_half && (req_addr[1:0] != 2'b00));
    end

    // Little-endian lane replacement over the word just read back.
    always_comb begin
        byte_lsb = {off_q, 3'b000};
        half_lsb = {off_q[1], 4'b0000};
        merged   = mem_rdata;
        if (is_byte_q) begin
            merged[byte_lsb +: 8] = data_q[7:0];
        end else begin
            merged[half_lsb +: 16] = data_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        data_d     = data_q;
        is_byte_d  = is_byte_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        err_flag_d = err_flag_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = {req_addr[31:2], 2'b00};
                    off_d      = req_addr[1:0];
                    data_d     = req_data[15:0];
                    is_byte_d  = req_is_byte;
                    wait_d     = '0;
                    err_flag_d = 1'b0;
                    if (req_misaligned) begin
                        state_d    = RESP;
                        err_flag_d = 1'b1;
                    end else if (req_is_byte || req_is_half) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                        wdata_d = req_data;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_d = WRITE;
                    wdata_d = merged;
                    wait_d  = '0;
                end else if (wait_q == LAST_WAIT) begin
                    state_d    = RESP;
                    err_flag_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    err_flag_d = 1'b0;
                end else if (wait_q == LAST_WAIT) begin
                    state_d    = RESP;
                    err_flag_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                wait_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            data_q     <= '0;
            is_byte_q  <= 1'b0;
            wdata_q    <= '0;
            wait_q     <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            data_q     <= data_d;
            is_byte_q  <= is_byte_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Strobes decode straight from the state so reset drops them immediately.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_re    = (state_q == READ);
        mem_we    = (state_q == WRITE);
        done      = (state_q == RESP) && !err_flag_q;
        err       = (state_q == RESP) && err_flag_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule
